// File: rtl/imuldiv_int_div_arbiter_pkg.sv
// Shared divider message definitions: field widths, port tags and the
// request message layout used by the divider arbiter.
package imuldiv_int_div_arbiter_pkg;

  // Message field widths
  localparam int unsigned FN_W     = 1;
  localparam int unsigned OPND_W   = 32;
  localparam int unsigned RESULT_W = 64;

  // Requester tags
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Operand bundle as latched by the divider in the fire cycle
  typedef struct packed {
    logic [FN_W-1:0]   fn;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } div_req_msg_t;

endpackage

// File: rtl/imuldiv_int_div_arbiter_respbuf.sv
// One-entry val/rdy buffer carrying a divider result and its owner tag.
// The enqueue side is ready only while the entry is empty, judged from the
// registered valid bit, so no combinational path exists from the consumer.
module imuldiv_DivRespBuf
  import imuldiv_int_div_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enq_val,
  output logic                o_enq_rdy,
  input  logic [TAG_W-1:0]    i_enq_tag,
  input  logic [RESULT_W-1:0] i_enq_data,
  output logic                o_deq_val,
  input  logic                i_deq_rdy,
  output logic [TAG_W-1:0]    o_deq_tag,
  output logic [RESULT_W-1:0] o_deq_data
);

  logic                r_val;
  logic [TAG_W-1:0]    r_tag;
  logic [RESULT_W-1:0] r_data;
  logic                w_enq_fire;
  logic                w_deq_fire;

  assign o_enq_rdy  = reset & ~r_val;
  assign o_deq_val  = reset & r_val;
  assign o_deq_tag  = r_tag;
  assign o_deq_data = r_data;
  assign w_enq_fire = i_enq_val & o_enq_rdy;
  assign w_deq_fire = o_deq_val & i_deq_rdy;

  // Entry state: load on enqueue, clear on dequeue
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_val  <= 1'b0;
      r_tag  <= '0;
      r_data <= '0;
    end else if (w_enq_fire) begin
      r_val  <= 1'b1;
      r_tag  <= i_enq_tag;
      r_data <= i_enq_data;
    end else if (w_deq_fire) begin
      r_val  <= 1'b0;
    end
  end

endmodule

// File: rtl/imuldiv_int_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters.
// Tracks the single in-flight operation's owner and returns the result
// through a one-entry tagged buffer so the divider can go idle while the
// owner is stalled.
module imuldiv_int_div_arbiter
  import imuldiv_int_div_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                req0_val,
  output logic                req0_rdy,
  input  logic                req0_msg_fn,
  input  logic [OPND_W-1:0]   req0_msg_a,
  input  logic [OPND_W-1:0]   req0_msg_b,
  output logic                resp0_val,
  input  logic                resp0_rdy,
  output logic [RESULT_W-1:0] resp0_msg_result,

  input  logic                req1_val,
  output logic                req1_rdy,
  input  logic                req1_msg_fn,
  input  logic [OPND_W-1:0]   req1_msg_a,
  input  logic [OPND_W-1:0]   req1_msg_b,
  output logic                resp1_val,
  input  logic                resp1_rdy,
  output logic [RESULT_W-1:0] resp1_msg_result,

  output logic                divreq_val,
  input  logic                divreq_rdy,
  output logic                divreq_msg_fn,
  output logic [OPND_W-1:0]   divreq_msg_a,
  output logic [OPND_W-1:0]   divreq_msg_b,
  input  logic                divresp_val,
  output logic                divresp_rdy,
  input  logic [RESULT_W-1:0] divresp_msg_result
);

  localparam int unsigned TAG_W = $clog2(NUM_PORTS);

  logic                r_busy;
  logic [TAG_W-1:0]    r_owner;
  logic [TAG_W-1:0]    r_prio;

  logic                w_issue_ok;
  logic [TAG_W-1:0]    w_grant;
  div_req_msg_t        w_req0;
  div_req_msg_t        w_req1;
  div_req_msg_t        w_greq;
  logic                w_req_fire;
  logic                w_divresp_fire;

  logic                w_buf_enq_rdy;
  logic                w_buf_val;
  logic [TAG_W-1:0]    w_buf_tag;
  logic [RESULT_W-1:0] w_buf_data;
  logic                w_buf_deq_rdy;

  assign w_req0 = {req0_msg_fn, req0_msg_a, req0_msg_b};
  assign w_req1 = {req1_msg_fn, req1_msg_a, req1_msg_b};

  // Issue only when no operation is outstanding and not in reset
  assign w_issue_ok = reset & ~r_busy;

  // Grant: priority port on contention, otherwise whichever port is valid
  always_comb begin
    w_grant = PORT0;
    if (req0_val && req1_val) begin
      w_grant = r_prio;
    end else if (req1_val) begin
      w_grant = PORT1;
    end
  end

  assign w_greq        = (w_grant == PORT1) ? w_req1 : w_req0;
  assign divreq_val    = w_issue_ok & (req0_val | req1_val);
  assign divreq_msg_fn = w_greq.fn;
  assign divreq_msg_a  = w_greq.a;
  assign divreq_msg_b  = w_greq.b;

  assign req0_rdy = w_issue_ok & (w_grant == PORT0) & divreq_rdy;
  assign req1_rdy = w_issue_ok & (w_grant == PORT1) & divreq_rdy;

  assign w_req_fire     = divreq_val & divreq_rdy;
  assign divresp_rdy    = w_buf_enq_rdy;
  assign w_divresp_fire = divresp_val & divresp_rdy;

  // Occupancy, owner tag and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_owner <= PORT0;
      r_prio  <= PORT0;
    end else begin
      if (w_divresp_fire) begin
        r_busy <= 1'b0;
      end
      if (w_req_fire) begin
        r_busy  <= 1'b1;
        r_owner <= w_grant;
        r_prio  <= ~w_grant;
      end
    end
  end

  // Delivery handshake follows whichever port owns the buffered result
  assign w_buf_deq_rdy = (w_buf_tag == PORT1) ? resp1_rdy : resp0_rdy;

  imuldiv_DivRespBuf #(
    .TAG_W (TAG_W)
  ) u_respbuf (
    .clk        (clk),
    .reset      (reset),
    .i_enq_val  (divresp_val),
    .o_enq_rdy  (w_buf_enq_rdy),
    .i_enq_tag  (r_owner),
    .i_enq_data (divresp_msg_result),
    .o_deq_val  (w_buf_val),
    .i_deq_rdy  (w_buf_deq_rdy),
    .o_deq_tag  (w_buf_tag),
    .o_deq_data (w_buf_data)
  );

  assign resp0_val        = w_buf_val & (w_buf_tag == PORT0);
  assign resp1_val        = w_buf_val & (w_buf_tag == PORT1);
  assign resp0_msg_result = w_buf_data;
  assign resp1_msg_result = w_buf_data;

endmodule

// File: tb/tb_imuldiv_int_div_arbiter.sv
// Bench for the two-port divider arbiter: a behavioural iterative divider
// sits behind the DUT, directed requests push hand-computed results into a
// scoreboard, and a monitor pops and compares on every response handshake.
module tb_imuldiv_int_div_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_val, req0_rdy, req0_msg_fn;
  logic [31:0] req0_msg_a, req0_msg_b;
  logic        resp0_val, resp0_rdy;
  logic [63:0] resp0_msg_result;
  logic        req1_val, req1_rdy, req1_msg_fn;
  logic [31:0] req1_msg_a, req1_msg_b;
  logic        resp1_val, resp1_rdy;
  logic [63:0] resp1_msg_result;
  logic        divreq_val, divreq_rdy, divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divresp_val, divresp_rdy;
  logic [63:0] divresp_msg_result;

  imuldiv_int_div_arbiter #(
    .NUM_PORTS (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req0_val           (req0_val),
    .req0_rdy           (req0_rdy),
    .req0_msg_fn        (req0_msg_fn),
    .req0_msg_a         (req0_msg_a),
    .req0_msg_b         (req0_msg_b),
    .resp0_val          (resp0_val),
    .resp0_rdy          (resp0_rdy),
    .resp0_msg_result   (resp0_msg_result),
    .req1_val           (req1_val),
    .req1_rdy           (req1_rdy),
    .req1_msg_fn        (req1_msg_fn),
    .req1_msg_a         (req1_msg_a),
    .req1_msg_b         (req1_msg_b),
    .resp1_val          (resp1_val),
    .resp1_rdy          (resp1_rdy),
    .resp1_msg_result   (resp1_msg_result),
    .divreq_val         (divreq_val),
    .divreq_rdy         (divreq_rdy),
    .divreq_msg_fn      (divreq_msg_fn),
    .divreq_msg_a       (divreq_msg_a),
    .divreq_msg_b       (divreq_msg_b),
    .divresp_val        (divresp_val),
    .divresp_rdy        (divresp_rdy),
    .divresp_msg_result (divresp_msg_result)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: IDLE -> RUN (33 edges) -> DONE, giving a 34-cycle
  // request-fire to response-valid latency through the arbiter.
  int          dv_st  = 0;
  int          dv_cnt = 0;
  logic [63:0] dv_res = '0;

  function automatic logic [63:0] div_ref(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (fn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      dv_st  <= 0;
      dv_cnt <= 0;
    end else begin
      case (dv_st)
        0: if (divreq_val && divreq_rdy) begin
             dv_st  <= 1;
             dv_cnt <= 0;
             dv_res <= div_ref(divreq_msg_fn, divreq_msg_a, divreq_msg_b);
           end
        1: if (dv_cnt == 32) dv_st <= 2; else dv_cnt <= dv_cnt + 1;
        default: if (divresp_rdy) dv_st <= 0;
      endcase
    end
  end

  assign divreq_rdy         = (dv_st == 0);
  assign divresp_val        = (dv_st == 2);
  assign divresp_msg_result = dv_res;

  typedef struct {
    int          port;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   resp_cnt = 0;
  int   fire_cyc = 0;
  int   last_cyc[2];
  logic r1_seen  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon_port(input int p, input logic [63:0] d);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL resp%0d_unexpected: got %h expected no response", p, d);
    end else begin
      e = sb_q.pop_front();
      if (e.port != p || e.data !== d) begin
        n_fail++;
        $display("FAIL resp%0d_data: got port %0d data %h expected port %0d data %h",
                 p, p, d, e.port, e.data);
      end
    end
    resp_cnt++;
    last_cyc[p] = cyc;
  endtask

  // Monitor: every response handshake is checked against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (resp1_val) r1_seen = 1'b1;
      if (resp0_val && resp0_rdy) mon_port(0, resp0_msg_result);
      if (resp1_val && resp1_rdy) mon_port(1, resp1_msg_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic fn, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_val = v; req0_msg_fn = fn; req0_msg_a = a; req0_msg_b = b;
    end else begin
      req1_val = v; req1_msg_fn = fn; req1_msg_a = a; req1_msg_b = b;
    end
  endtask

  task automatic issue(input int p, input logic fn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    bit fired = 0;
    int i = 0;
    drive(p, 1'b1, fn, a, b);
    while (!fired && i < 300) begin
      @(negedge clk);
      if ((p == 0) ? req0_rdy : req1_rdy) begin
        sb_q.push_back('{port: p, data: exp});
        fire_cyc = cyc + 1;
        fired = 1;
      end
      tick();
      i++;
    end
    drive(p, 1'b0, 1'b0, '0, '0);
    if (!fired) chk($sformatf("issue%0d_timeout", p), 64'd0, 64'd1);
  endtask

  task automatic both(input logic fn0, input logic [31:0] a0, input logic [31:0] b0, input logic [63:0] e0,
                      input logic fn1, input logic [31:0] a1, input logic [31:0] b1, input logic [63:0] e1,
                      input int exp_first);
    bit f0 = 0, f1 = 0;
    int first = -1;
    int i = 0;
    drive(0, 1'b1, fn0, a0, b0);
    drive(1, 1'b1, fn1, a1, b1);
    while (!(f0 && f1) && i < 300) begin
      @(negedge clk);
      if (req0_val && req0_rdy) begin
        sb_q.push_back('{port: 0, data: e0});
        f0 = 1;
        if (first < 0) first = 0;
      end
      if (req1_val && req1_rdy) begin
        sb_q.push_back('{port: 1, data: e1});
        f1 = 1;
        if (first < 0) first = 1;
      end
      tick();
      if (f0) req0_val = 1'b0;
      if (f1) req1_val = 1'b0;
      i++;
    end
    req0_val = 1'b0;
    req1_val = 1'b0;
    if (!(f0 && f1)) chk("both_timeout", 64'd0, 64'd1);
    chk("grant_order", 64'(first), 64'(exp_first));
  endtask

  task automatic wait_resp(input int target, input int bound);
    int i = 0;
    while (resp_cnt < target && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (resp_cnt < target) chk("resp_timeout", 64'(resp_cnt), 64'(target));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  int base;
  int i;

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    last_cyc[0] = 0;
    last_cyc[1] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'({req0_rdy, req1_rdy, resp0_val, resp1_val, divreq_val, divresp_rdy}), 64'b0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", 64'({divreq_val, divresp_rdy, resp0_val, resp1_val, req0_rdy, req1_rdy}), 64'b010010);
    tick();

    // Port 0 only, signed, latency
    r1_seen = 1'b0;
    base = resp_cnt;
    issue(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_resp(base + 1, 100);
    chk("latency", 64'(last_cyc[0] - fire_cyc), 64'd34);
    chk("resp1_quiet", 64'(r1_seen), 64'd0);

    // Contention right after reset; round-robin 0 -> 1 -> 0
    do_reset();
    base = resp_cnt;
    both(1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E,
         1'b0, 32'd20,  32'd3, 64'h0000_0002_0000_0006, 0);
    wait_resp(base + 2, 200);
    base = resp_cnt;
    both(1'b0, 32'd9, 32'd4, 64'h0000_0001_0000_0002,
         1'b0, 32'd1, 32'd1, 64'h0000_0000_0000_0001, 0);
    wait_resp(base + 2, 200);
    base = resp_cnt;
    issue(0, 1'b1, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2);
    wait_resp(base + 1, 100);
    base = resp_cnt;
    both(1'b0, 32'hFFFF_FFFF, 32'h10,        64'h0000_000F_0FFF_FFFF,
         1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1);
    wait_resp(base + 2, 200);

    // Backpressure on port 0 while port 1 issues
    resp0_rdy = 1'b0;
    base = resp_cnt;
    issue(0, 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    issue(1, 1'b0, 32'd20,  32'd3, 64'h0000_0002_0000_0006);
    i = 0;
    while (!divresp_val && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("divresp_rdy_full", 64'(divresp_rdy), 64'd0);
    tick();
    drive(0, 1'b1, 1'b0, 32'd1, 32'd1);
    repeat (5) tick();
    @(negedge clk);
    chk("hold_done", 64'({divresp_val, divreq_val, req0_rdy, req1_rdy}), 64'b1000);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    resp0_rdy = 1'b1;
    wait_resp(base + 2, 50);
    chk("drain_gap", 64'(last_cyc[1] - last_cyc[0]), 64'd2);

    // Reset mid-operation discards the operation
    issue(1, 1'b0, 32'd50, 32'd5, 64'h0000_0000_0000_000A);
    repeat (10) tick();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'd3, 32'd1);
    sb_q.delete();
    @(negedge clk);
    chk("reset_mid", 64'({req0_rdy, req1_rdy, resp0_val, resp1_val, divreq_val, divresp_rdy}), 64'b0);
    tick();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    base = resp_cnt;
    repeat (60) tick();
    chk("no_resp_after_reset", 64'(resp_cnt), 64'(base));

    // Divide by zero passes through unmodified
    issue(0, 1'b0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
    wait_resp(base + 1, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
